// File: rtl/fp_mul_iter_if.sv
// Handshake and data bundle for the iterative floating-point multiplier.
// The slave modport is the multiplier side; the master modport is the producer/consumer side.
interface fp_mul_iter_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, res, flags, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, res, flags, busy
    );
endinterface

// File: rtl/fp_mul_iter.sv
// Iterative IEEE-754-style multiplier: one radix-2 Booth step per cycle on the significands,
// then a single normalise/round/special-case cycle. Subnormal operands are flushed to zero.
// Optional feature: define FP_MUL_ITER_RNE_EN for round-to-nearest-even; otherwise the
// discarded bits are truncated (round toward zero).
module fp_mul_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic         clk,
    input logic         reset,
    fp_mul_iter_if.slave bus_io
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 1;
    localparam int unsigned PW   = 2 * SW;
    localparam int unsigned EW   = EXP_W + 2;
    localparam int unsigned CW   = $clog2(SW + 1);
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

    state_e                state_q;
    logic                  sign_q;
    logic signed [EW-1:0]  exp_q;
    logic                  nan_q, inf_q, zero_q;
    logic [PW-1:0]         acc_q;
    logic [PW-1:0]         mcs_q;
    logic [SW-1:0]         mplr_q;
    logic                  bm1_q;
    logic [CW-1:0]         cnt_q;
    logic [W-1:0]          res_q;
    logic [3:0]            flags_q;

    // Operand decode
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EW-1:0]    exp_sum;

    // Decode the incoming operands into exponent sum and special-case classes
    always_comb begin
        ea      = bus_io.a[W-2 -: EXP_W];
        eb      = bus_io.b[W-2 -: EXP_W];
        fa      = bus_io.a[MAN_W-1:0];
        fb      = bus_io.b[MAN_W-1:0];
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_inf   = (ea == '1) && (fa == '0);
        b_inf   = (eb == '1) && (fb == '0);
        a_nan   = (ea == '1) && (fa != '0);
        b_nan   = (eb == '1) && (fb != '0);
        exp_sum = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);
    end

    // One Booth step: the multiplier bit pair selects add, subtract or hold of the
    // left-shifted multiplicand. The accumulator starts at A<<SW to undo the signed
    // interpretation of the always-set hidden bit, so it never goes negative.
    logic [PW-1:0] acc_step;
    always_comb begin
        acc_step = acc_q;
        case ({mplr_q[0], bm1_q})
            2'b01:   acc_step = acc_q + mcs_q;
            2'b10:   acc_step = acc_q - mcs_q;
            default: acc_step = acc_q;
        endcase
    end

    // Normalise, round and apply special cases to the finished product
    logic [PW-1:0]        norm;
    logic                 msb, guard, sticky, rnd_up, carry;
    logic [MAN_W-1:0]     frac;
    logic [MAN_W:0]       frac_rnd;
    logic signed [EW-1:0] e_fin;
    logic [W-1:0]         res_n;
    logic [3:0]           flags_n;
    always_comb begin
        msb    = acc_q[PW-1];
        norm   = msb ? acc_q : (acc_q << 1);
        frac   = norm[PW-2 -: MAN_W];
        guard  = norm[PW-2-MAN_W];
        sticky = |norm[PW-3-MAN_W:0];
`ifdef FP_MUL_ITER_RNE_EN
        rnd_up = guard & (sticky | frac[0]);
`else
        rnd_up = 1'b0;
`endif
        frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        carry    = frac_rnd[MAN_W];
        e_fin    = exp_q + EW'(msb) + EW'(carry);
        res_n    = '0;
        flags_n  = '0;
        if (nan_q) begin
            // Canonical quiet NaN: positive, exponent all ones, fraction MSB only
            res_n[W-2 -: EXP_W+1] = '1;
            flags_n               = 4'b1000;
        end else if (inf_q) begin
            res_n[W-1]          = sign_q;
            res_n[W-2 -: EXP_W] = '1;
        end else if (zero_q) begin
            res_n[W-1] = sign_q;
        end else if ($signed(e_fin) >= $signed(EW'(EMAX))) begin
            res_n[W-1]          = sign_q;
            res_n[W-2 -: EXP_W] = '1;
            flags_n             = 4'b0101;
        end else if ($signed(e_fin) < $signed(EW'(1))) begin
            res_n[W-1] = sign_q;
            flags_n    = 4'b0011;
        end else begin
            res_n   = {sign_q, e_fin[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
            flags_n = {3'b000, guard | sticky};
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
            zero_q  <= 1'b0;
            acc_q   <= '0;
            mcs_q   <= '0;
            mplr_q  <= '0;
            bm1_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.in_valid) begin
                        sign_q  <= bus_io.a[W-1] ^ bus_io.b[W-1];
                        exp_q   <= exp_sum;
                        nan_q   <= a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
                        inf_q   <= a_inf | b_inf;
                        zero_q  <= a_zero | b_zero;
                        acc_q   <= {1'b1, fa, {SW{1'b0}}};
                        mcs_q   <= {{SW{1'b0}}, 1'b1, fa};
                        mplr_q  <= {1'b1, fb};
                        bm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    acc_q  <= acc_step;
                    mcs_q  <= mcs_q << 1;
                    mplr_q <= mplr_q >> 1;
                    bm1_q  <= mplr_q[0];
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(SW - 1)) begin
                        state_q <= StNorm;
                    end
                end
                StNorm: begin
                    res_q   <= res_n;
                    flags_q <= flags_n;
                    state_q <= StDone;
                end
                StDone: begin
                    if (bus_io.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.in_ready  = (state_q == StIdle);
    assign bus_io.out_valid = (state_q == StDone);
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.res       = res_q;
    assign bus_io.flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_iter.sv
// Self-checking bench for fp_mul_iter (single precision): directed vector table, a few
// random normal-range products against a reference model, hold and mid-operation reset.
module tb_fp_mul_iter;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned LAT   = MAN_W + 2;

`ifdef FP_MUL_ITER_RNE_EN
    localparam logic [31:0] R_TIE   = 32'h40100002;
    localparam logic [31:0] R_CARRY = 32'h40000000;
`else
    localparam logic [31:0] R_TIE   = 32'h40100001;
    localparam logic [31:0] R_CARRY = 32'h3FFFFFFF;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_mul_iter_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference for normal operands whose product stays in range
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma, mb, p;
        logic [22:0] fr;
        logic [23:0] fr_r;
        logic        g, s, up;
        logic [9:0]  e;
        exp_t        r;
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) begin
            fr = p[46:24]; g = p[23]; s = |p[22:0]; e = e + 10'd1;
        end else begin
            fr = p[45:23]; g = p[22]; s = |p[21:0];
        end
`ifdef FP_MUL_ITER_RNE_EN
        up = g & (s | fr[0]);
`else
        up = 1'b0;
`endif
        fr_r = {1'b0, fr} + {23'd0, up};
        if (fr_r[23]) e = e + 10'd1;
        r.res   = {a[31] ^ b[31], e[7:0], fr_r[22:0]};
        r.flags = {3'b000, g | s};
        return r;
    endfunction

    // Offer one operand pair and queue its expected result at the accepting edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        sb_q.push_back(e);
    endtask

    // Wait for the result (bounded), check latency and pop/compare against the scoreboard
    task automatic collect(input string name);
        int   n = 0;
        exp_t e;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(LAT));
        if (sb_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_res"}, 64'(bus.res), 64'(e.res));
            check({name, "_flags"}, 64'(bus.flags), 64'(e.flags));
        end
        tick();
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra, rb;
        bit          stale;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3FC00001, 32'h3FC00001, R_TIE,        4'b0001};
        vecs[2]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
        vecs[3]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101};
        vecs[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011};
        vecs[5]  = '{32'hBF800000, 32'h3F800000, 32'hBF800000, 4'b0000};
        vecs[6]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000};
        vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[8]  = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000};
        vecs[9]  = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000};
        vecs[10] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
        vecs[11] = '{32'hC0000000, 32'hC0400000, 32'h40C00000, 4'b0000};
        vecs[12] = '{32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000};
        vecs[13] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        vecs[14] = '{32'h3F842108, 32'h3FF80000, R_CARRY,      4'b0001};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        reset         = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_res", 64'(bus.res), 64'd0);
        check("reset_flags", 64'(bus.flags), 64'd0);

        // Directed table
        for (int i = 0; i < 15; i++) begin
            e.res   = vecs[i].res;
            e.flags = vecs[i].flags;
            issue(vecs[i].a, vecs[i].b, e);
            check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'd1);
            collect($sformatf("vec%0d", i));
        end

        // Random normal-range products
        for (int i = 0; i < 6; i++) begin
            ra = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
            rb = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
            issue(ra, rb, model(ra, rb));
            collect($sformatf("rand%0d", i));
        end

        // Hold the result with out_ready low while a new operand is offered
        bus.out_ready = 1'b0;
        e.res   = 32'h40400000;
        e.flags = 4'b0000;
        issue(32'h3FC00000, 32'h40000000, e);
        begin
            int n = 0;
            while (!bus.out_valid && n < 100) begin
                tick();
                n++;
            end
            check("hold_latency", 64'(n), 64'(LAT));
        end
        e = sb_q.pop_front();
        bus.a        = 32'h40000000;
        bus.b        = 32'h40000000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold%0d_res", i), 64'(bus.res), 64'(e.res));
            check($sformatf("hold%0d_flags", i), 64'(bus.flags), 64'(e.flags));
            check($sformatf("hold%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("hold%0d_in_ready", i), 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("release_out_valid", 64'(bus.out_valid), 64'd0);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_busy", 64'(bus.busy), 64'd0);
        tick();
        check("release_no_accept", 64'(bus.busy), 64'd0);

        // Reset in the middle of the Booth iterations
        e.res   = 32'h40C00000;
        e.flags = 4'b0000;
        issue(32'hC0000000, 32'hC0400000, e);
        void'(sb_q.pop_back());
        repeat (4) tick();
        check("midmul_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        check("midreset_busy", 64'(bus.busy), 64'd0);
        check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
        check("midreset_res", 64'(bus.res), 64'd0);
        check("midreset_flags", 64'(bus.flags), 64'd0);
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) stale = 1'b1;
        end
        check("midreset_no_stale_result", 64'(stale), 64'd0);

        // Normal operation after the aborted one
        e.res   = 32'h40C00000;
        e.flags = 4'b0000;
        issue(32'hC0000000, 32'hC0400000, e);
        collect("post_reset");

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_mul_iter.md
FP_MUL_ITER -- requirements
Module: fp_mul_iter

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 23, stored fraction width; the total operand width W = 1+EXP_W+MAN_W.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have ports in_valid input 1 (operand pair offered) and in_ready output 1 (block can accept).
REQ-006 The block SHALL have ports a input W and b input W, the IEEE-754-style operands.
REQ-007 The block SHALL have ports out_valid output 1 (result held) and out_ready input 1 (consumer accepts).
REQ-008 The block SHALL have port res, output, W, the product.
REQ-009 The block SHALL have port flags, output, 4, with bit3 invalid, bit2 overflow, bit1 underflow and bit0 inexact.
REQ-010 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, MUL, NORM and DONE; in_ready is 1 only in IDLE, and out_valid is 1 only in DONE.
REQ-012 In IDLE with in_valid=1, the block SHALL register a, b and the decoded sign/exponent/special-case class, clear the step counter, and move to MUL.
REQ-013 MUL SHALL perform one radix-2 Booth step per cycle on the (MAN_W+1)-bit significands {1,frac}, for exactly MAN_W+1 cycles, giving a 2*(MAN_W+1)-bit product, and then move to NORM.
REQ-014 NORM SHALL normalise, round, apply special cases and register res/flags in one cycle, then move to DONE.
REQ-015 out_valid SHALL first assert MAN_W+2 cycles after the accepting edge (25 for defaults); special-case operands take the same latency.
REQ-016 In DONE, res/flags SHALL remain stable while out_ready=0; out_ready=1 SHALL return the FSM to IDLE, and no new operand is accepted in that same cycle.
REQ-017 The exponent SHALL be computed as EA+EB-bias, with bias = 2^(EXP_W-1)-1, in EXP_W+2-bit signed arithmetic; it is incremented when the product MSB is set, and again on a rounding carry-out.
REQ-018 An operand with exponent 0 SHALL be treated as zero (subnormal flush); a final exponent <=0 SHALL give a signed zero with underflow=1 and inexact=1.
REQ-019 A final exponent >= 2^EXP_W-1 SHALL give a signed infinity with overflow=1 and inexact=1.
REQ-020 Either operand NaN, or zero times infinity, SHALL give canonical quiet NaN: sign 0, exponent all ones, fraction MSB 1 and the rest 0, with invalid=1.
REQ-021 Infinity times a non-zero finite value SHALL give a signed infinity with flags=0; zero times a finite value SHALL give a signed zero with flags=0.
REQ-022 The result sign SHALL always be sign(a) XOR sign(b), except for NaN.
REQ-023 inexact SHALL be set whenever any discarded product bit is non-zero.

Reset
REQ-024 When reset=1 at a rising edge, the FSM SHALL go to IDLE, and res, flags, the step counter and all internal registers SHALL clear to 0.
REQ-025 After reset, out_valid=0, busy=0 and in_ready=1.
REQ-026 Reset SHALL override every other input; a reset mid-MUL or in DONE discards the operation without producing a result.

Configuration
REQ-027 With macro FP_MUL_ITER_RNE_EN defined, NORM SHALL round to nearest, ties to even, using the guard bit and the OR of the lower bits (sticky).
REQ-028 Without FP_MUL_ITER_RNE_EN, NORM SHALL truncate the discarded bits (round toward zero) and never produce a rounding carry; flag behaviour is otherwise identical.

Verification
REQ-029 a=0x3FC00000, b=0x40000000 -> res=0x40400000, flags=0, out_valid exactly 25 cycles after acceptance.
REQ-030 a=0x3FC00001, b=0x3FC00001 -> res=0x40100002 with RNE_EN and 0x40100001 without; inexact=1 in both builds.
REQ-031 a=0x00000000, b=0x7F800000 -> res=0x7FC00000, flags=0b1000; a=0x7F7FFFFF, b=0x40000000 -> res=0x7F800000, flags=0b0101.
REQ-032 a=0x00800000, b=0x00800000 -> res=0x00000000, flags=0b0011; a=0xBF800000, b=0x3F800000 -> res=0xBF800000.
REQ-033 Hold out_ready=0 for 10 cycles after out_valid -> res stable, in_ready=0 and a new in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-034 Assert reset during MUL step 5 -> next cycle state IDLE, out_valid=0, res=0, and no stale result appears afterwards.
